// File: rtl/rt_loader_pkg.sv
// Shared types and constants for the racetrack/LiM firmware preloader.
package rt_loader_pkg;

    // Loader sequencing: gather a word, write it, wait, then release the core.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        SETTLE  = 3'd3,
        DONE    = 3'd4
    } loader_state_e;

    localparam int         WORD_BYTES    = 4;
    localparam int         ADDR_STRIDE   = 4;
    localparam logic [2:0] LIM_FUNCT_NOP = 3'b000;

endpackage

// File: rtl/rt_mem_loader_if.sv
// Byte-stream input and dp_ram port-B bus of the firmware preloader.
// Signal suffixes are given from the loader's point of view.
interface rt_mem_loader_if #(
    parameter int RAM_ADDR_WIDTH = 22
);
    logic                      byte_valid_i;
    logic [7:0]                byte_i;
    logic                      byte_ready_o;
    logic                      mem_ready_i;
    logic                      en_b_o;
    logic                      we_b_o;
    logic [3:0]                be_b_o;
    logic [RAM_ADDR_WIDTH-1:0] addr_b_o;
    logic [31:0]               wdata_b_o;
    logic [2:0]                lim_funct_o;
    logic                      we_b_funct_mem_o;
    logic [RAM_ADDR_WIDTH-1:0] addr_b_range_o;

    // Loader side: consumes bytes, drives memory port B.
    modport master (
        input  byte_valid_i, byte_i, mem_ready_i,
        output byte_ready_o, en_b_o, we_b_o, be_b_o, addr_b_o, wdata_b_o,
               lim_funct_o, we_b_funct_mem_o, addr_b_range_o
    );

    // Environment side: byte source plus memory.
    modport slave (
        output byte_valid_i, byte_i, mem_ready_i,
        input  byte_ready_o, en_b_o, we_b_o, be_b_o, addr_b_o, wdata_b_o,
               lim_funct_o, we_b_funct_mem_o, addr_b_range_o
    );
endinterface

// File: rtl/rt_byte_packer.sv
// Packs little-endian bytes into 32-bit words: three bytes are held in a
// lane shift register and the fourth completes the word combinationally.
module rt_byte_packer
    import rt_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        take_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] lanes_q, lanes_d;

    // Advance the byte index and shift earlier bytes toward lane 0.
    always_comb begin
        idx_d   = idx_q;
        lanes_d = lanes_q;
        if (clear_i) begin
            idx_d = 2'd0;
        end else if (take_i) begin
            if (idx_q == LAST_IDX) begin
                idx_d = 2'd0;
            end else begin
                idx_d   = idx_q + 2'd1;
                lanes_d = {byte_i, lanes_q[23:8]};
            end
        end
    end

    // Index and lanes; reset discards any partial word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q   <= 2'd0;
            lanes_q <= 24'd0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

    assign word_valid_o = take_i && !clear_i && (idx_q == LAST_IDX);
    assign word_o       = {byte_i, lanes_q};

endmodule

// File: rtl/rt_mem_loader.sv
// Firmware preloader for the racetrack/LiM data memory. Packs a byte stream
// into words, writes them sequentially through port B with LiM controls held
// inactive, then raises a sticky fetch enable.
// Optional feature: define RT_LOADER_CHECKSUM_EN to add checksum_o (sum of
// all written words) and checksum_valid_o (high in DONE).
module rt_mem_loader
    import rt_loader_pkg::*;
#(
    parameter int                        RAM_ADDR_WIDTH = 22,
    parameter logic [RAM_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        CNT_WIDTH      = 16,
    parameter int                        SETTLE_CYCLES  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] num_words_i,
    rt_mem_loader_if.master      bus,
    output logic                 busy_o,
    output logic                 fetch_enable_o
`ifdef RT_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]          checksum_o,
    output logic                 checksum_valid_o
`endif
);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1) + 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);

    loader_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]      rem_q, rem_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic                      wr_q, wr_d;
    logic [3:0]                be_q, be_d;
    logic                      fetch_q, fetch_d;
    logic [SETTLE_W-1:0]       settle_q, settle_d;

    logic        start_ok;
    logic        pk_take;
    logic        pk_word_valid;
    logic [31:0] pk_word;
    logic        wr_accept;

    assign start_ok  = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign pk_take   = bus.byte_valid_i && (state_q == COLLECT);
    assign wr_accept = (state_q == WRITE) && bus.mem_ready_i;

    rt_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (start_ok),
        .take_i       (pk_take),
        .byte_i       (bus.byte_i),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        be_d     = be_q;
        fetch_d  = fetch_q;
        settle_d = settle_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    rem_d    = num_words_i;
                    addr_d   = BASE_ADDR;
                    settle_d = '0;
                    state_d  = (num_words_i == '0) ? SETTLE : COLLECT;
                end
            end
            COLLECT: begin
                if (pk_word_valid) begin
                    wdata_d = pk_word;
                    wr_d    = 1'b1;
                    be_d    = 4'hF;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.mem_ready_i) begin
                    wr_d   = 1'b0;
                    be_d   = 4'h0;
                    addr_d = addr_q + RAM_ADDR_WIDTH'(ADDR_STRIDE);
                    rem_d  = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) begin
                        settle_d = '0;
                        state_d  = SETTLE;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    fetch_d = 1'b1;
                    state_d = DONE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, address, write data and registered port-B controls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q    <= '0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= 32'd0;
            wr_q     <= 1'b0;
            be_q     <= 4'h0;
            fetch_q  <= 1'b0;
            settle_q <= '0;
        end else begin
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            fetch_q  <= fetch_d;
            settle_q <= settle_d;
        end
    end

`ifdef RT_LOADER_CHECKSUM_EN
    logic [31:0] cs_q, cs_d;
    logic        csv_q;

    // Running sum of accepted words, restarted with each load.
    always_comb begin
        cs_d = cs_q;
        if (start_ok) begin
            cs_d = 32'd0;
        end else if (wr_accept) begin
            cs_d = cs_q + wdata_q;
        end
    end

    // Checksum register and its DONE-qualified valid flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_q  <= 32'd0;
            csv_q <= 1'b0;
        end else begin
            cs_q  <= cs_d;
            csv_q <= (state_d == DONE);
        end
    end

    assign checksum_o       = cs_q;
    assign checksum_valid_o = csv_q;
`endif

    assign bus.byte_ready_o     = (state_q == COLLECT);
    assign bus.en_b_o           = wr_q;
    assign bus.we_b_o           = wr_q;
    assign bus.be_b_o           = be_q;
    assign bus.addr_b_o         = addr_q;
    assign bus.wdata_b_o        = wdata_q;
    assign bus.lim_funct_o      = LIM_FUNCT_NOP;
    assign bus.we_b_funct_mem_o = 1'b0;
    assign bus.addr_b_range_o   = '0;

    assign busy_o         = (state_q == COLLECT) || (state_q == WRITE) || (state_q == SETTLE);
    assign fetch_enable_o = fetch_q;

endmodule
